// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one bypassed write port,
// a per-register pending-write scoreboard and a one-entry-per-cycle clear engine.
module regfile_sb #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    SrcReg1,
  input  logic [AW-1:0]    SrcReg2,
  output logic [WIDTH-1:0] SrcData1,
  output logic [WIDTH-1:0] SrcData2,
  output logic             Src1Busy,
  output logic             Src2Busy,
  input  logic [AW-1:0]    DstReg,
  input  logic             WriteReg,
  input  logic [WIDTH-1:0] DstData,
  input  logic             Reserve,
  input  logic [AW-1:0]    ReserveReg,
  input  logic             ClearReq,
  output logic             Busy
);

  localparam logic ZR = (ZERO_REG != 0);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   idx_reg, idx_next;
  logic [WIDTH-1:0] rf_q [DEPTH];
  logic [DEPTH-1:0] pend_q;

  logic idle;
  logic issue;
  logic wr_ok;
  logic res_ok;
  logic byp_ok;

  assign idle   = (state_reg == IDLE);
  // A clear request in IDLE swallows any write/reserve presented alongside it.
  assign issue  = idle & !ClearReq;
  assign wr_ok  = WriteReg & issue & !(ZR && (DstReg == '0));
  assign res_ok = Reserve & issue & !(ZR && (ReserveReg == '0));
  assign byp_ok = WriteReg & idle & !(ZR && (DstReg == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    Busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ClearReq) begin
          state_next = CLEAR;
          idx_next   = '0;
        end
      end
      CLEAR: begin
        Busy     = 1'b1;
        idx_next = idx_reg + AW'(1);
        if (idx_reg == AW'(DEPTH - 1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_reg;
      logic             pend_reg;
      logic             wr_hit;
      logic             res_hit;
      logic             clr_hit;

      assign wr_hit  = wr_ok & (DstReg == AW'(gi));
      assign res_hit = res_ok & (ReserveReg == AW'(gi));
      assign clr_hit = (state_reg == CLEAR) & (idx_reg == AW'(gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_reg <= '0;
        end else if (clr_hit) begin
          entry_reg <= '0;
        end else if (wr_hit) begin
          entry_reg <= DstData;
        end
      end

      // Reserve outranks write-back: the newly issued producer supersedes the old one.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pend_reg <= 1'b0;
        end else if (idle & ClearReq) begin
          pend_reg <= 1'b0;
        end else if (res_hit) begin
          pend_reg <= 1'b1;
        end else if (wr_hit) begin
          pend_reg <= 1'b0;
        end
      end

      assign rf_q[gi]   = entry_reg;
      assign pend_q[gi] = pend_reg;
    end
  endgenerate

  logic [AW-1:0]    src_addr [2];
  logic [WIDTH-1:0] src_data [2];
  logic             src_busy [2];

  assign src_addr[0] = SrcReg1;
  assign src_addr[1] = SrcReg2;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [WIDTH-1:0] rd_data;
      logic             match;

      assign match = (DstReg == src_addr[gi]);

      always_comb begin
        rd_data = rf_q[src_addr[gi]];
        if (ZR && (src_addr[gi] == '0)) begin
          rd_data = '0;
        end else if (byp_ok & match) begin
          rd_data = DstData;
        end
      end

      // The write-back in flight covers the hazard, so it never reports busy.
      assign src_busy[gi] = idle & pend_q[src_addr[gi]] & !(WriteReg & match);
      assign src_data[gi] = rd_data;
    end
  endgenerate

  assign SrcData1 = src_data[0];
  assign SrcData2 = src_data[1];
  assign Src1Busy = src_busy[0];
  assign Src2Busy = src_busy[1];

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two instances (16x16 with zero register, 32x32 without)
// checked every cycle against an array/flag model, plus directed literal checks.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst;

  logic [4:0]  sr1 [2];
  logic [4:0]  sr2 [2];
  logic [4:0]  dst [2];
  logic [4:0]  rr  [2];
  logic        wr  [2];
  logic        res [2];
  logic        clr [2];
  logic [31:0] dd  [2];

  logic [15:0] a_d1, a_d2;
  logic [31:0] b_d1, b_d2;
  logic        a_b1, a_b2, a_busy;
  logic        b_b1, b_b2, b_busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regfile_sb #(.WIDTH(16), .DEPTH(16), .ZERO_REG(1)) u_a (
    .clk(clk), .rst(rst),
    .SrcReg1(sr1[0][3:0]), .SrcReg2(sr2[0][3:0]),
    .SrcData1(a_d1), .SrcData2(a_d2),
    .Src1Busy(a_b1), .Src2Busy(a_b2),
    .DstReg(dst[0][3:0]), .WriteReg(wr[0]), .DstData(dd[0][15:0]),
    .Reserve(res[0]), .ReserveReg(rr[0][3:0]),
    .ClearReq(clr[0]), .Busy(a_busy)
  );

  regfile_sb #(.WIDTH(32), .DEPTH(32), .ZERO_REG(0)) u_b (
    .clk(clk), .rst(rst),
    .SrcReg1(sr1[1]), .SrcReg2(sr2[1]),
    .SrcData1(b_d1), .SrcData2(b_d2),
    .Src1Busy(b_b1), .Src2Busy(b_b2),
    .DstReg(dst[1]), .WriteReg(wr[1]), .DstData(dd[1]),
    .Reserve(res[1]), .ReserveReg(rr[1]),
    .ClearReq(clr[1]), .Busy(b_busy)
  );

  // Reference model: register contents, pending flags, clear-in-progress flag and position.
  logic [31:0] mm  [2][32];
  bit          mp  [2][32];
  bit          mcl [2];
  int          midx[2];

  function automatic int dep(int k);
    return (k == 0) ? 16 : 32;
  endfunction

  function automatic bit zr(int k);
    return (k == 0);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_data(int k, logic [4:0] a);
    if (mcl[k]) return mm[k][a];
    if (zr(k) && a == 0) return 32'h0;
    if (wr[k] && dst[k] == a && !(zr(k) && dst[k] == 0)) return dd[k];
    return mm[k][a];
  endfunction

  function automatic bit exp_busy(int k, logic [4:0] a);
    return !mcl[k] && mp[k][a] && !(wr[k] && dst[k] == a);
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 32; i++) begin
          mm[k][i] = 32'h0;
          mp[k][i] = 1'b0;
        end
        mcl[k]  = 1'b0;
        midx[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (mcl[k]) begin
          mm[k][midx[k]] = 32'h0;
          midx[k]++;
          if (midx[k] == dep(k)) mcl[k] = 1'b0;
        end else if (clr[k]) begin
          mcl[k]  = 1'b1;
          midx[k] = 0;
          for (int i = 0; i < 32; i++) mp[k][i] = 1'b0;
        end else begin
          if (wr[k] && !(zr(k) && dst[k] == 0)) begin
            mm[k][dst[k]] = dd[k];
            mp[k][dst[k]] = 1'b0;
          end
          if (res[k] && !(zr(k) && rr[k] == 0)) mp[k][rr[k]] = 1'b1;
        end
      end
    end
  end

  logic [31:0] o_d1, o_d2;
  logic        o_b1, o_b2, o_bz;

  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      o_d1 = (k == 0) ? {16'h0, a_d1} : b_d1;
      o_d2 = (k == 0) ? {16'h0, a_d2} : b_d2;
      o_b1 = (k == 0) ? a_b1 : b_b1;
      o_b2 = (k == 0) ? a_b2 : b_b2;
      o_bz = (k == 0) ? a_busy : b_busy;
      chk($sformatf("u%0d SrcData1", k), o_d1, exp_data(k, sr1[k]));
      chk($sformatf("u%0d SrcData2", k), o_d2, exp_data(k, sr2[k]));
      chk($sformatf("u%0d Src1Busy", k), 32'(o_b1), 32'(exp_busy(k, sr1[k])));
      chk($sformatf("u%0d Src2Busy", k), 32'(o_b2), 32'(exp_busy(k, sr2[k])));
      chk($sformatf("u%0d Busy", k), 32'(o_bz), 32'(mcl[k]));
    end
  end

  task automatic quiet();
    for (int k = 0; k < 2; k++) begin
      wr[k]  = 1'b0;
      res[k] = 1'b0;
      clr[k] = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic wr_reg(int k, int a, logic [31:0] d);
    quiet();
    wr[k]  = 1'b1;
    dst[k] = 5'(a);
    dd[k]  = (k == 0) ? (d & 32'hFFFF) : d;
    step();
    wr[k] = 1'b0;
  endtask

  initial begin
    int dep_k;
    int busycnt;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sr1[k] = '0; sr2[k] = '0; dst[k] = '0; rr[k] = '0; dd[k] = '0;
    end
    quiet();
    repeat (3) @(posedge clk);
    #1;
    sample();
    chk("reset SrcData1", 32'(a_d1), 32'h0);
    chk("reset Busy", 32'(a_busy), 32'h0);
    step();
    rst = 1'b0;

    // Basic write then read on both ports
    wr_reg(0, 15, 32'hFFFF);
    wr_reg(0, 1, 32'h1234);
    sr1[0] = 5'd1;
    sr2[0] = 5'd15;
    sample();
    chk("read r1", 32'(a_d1), 32'h1234);
    chk("read r15", 32'(a_d2), 32'hFFFF);
    chk("read busy1", 32'(a_b1), 32'h0);
    chk("read busy2", 32'(a_b2), 32'h0);
    step();

    // Bypass: no zero register, then register 0 on the zero-register instance
    sr2[1] = 5'd0;
    wr[1] = 1'b1; dst[1] = 5'd5; dd[1] = 32'h8765; sr1[1] = 5'd5;
    sample();
    chk("bypass r5", b_d1, 32'h8765);
    chk("r0 holds 0", b_d2, 32'h0);
    step();
    wr[1] = 1'b0;
    sample();
    chk("r5 after edge", b_d1, 32'h8765);
    step();
    wr[0] = 1'b1; dst[0] = 5'd0; dd[0] = 32'h8765; sr1[0] = 5'd0;
    sample();
    chk("zero reg bypass", 32'(a_d1), 32'h0);
    step();
    wr[0] = 1'b0;
    sample();
    chk("zero reg after edge", 32'(a_d1), 32'h0);
    step();

    // Scoreboard on r9
    res[0] = 1'b1; rr[0] = 5'd9; sr2[0] = 5'd9;
    step();
    res[0] = 1'b0;
    sample();
    chk("r9 reserved", 32'(a_b2), 32'h1);
    step();
    wr[0] = 1'b1; dst[0] = 5'd9; dd[0] = 32'hABCD;
    sample();
    chk("r9 writeback busy", 32'(a_b2), 32'h0);
    chk("r9 writeback data", 32'(a_d2), 32'hABCD);
    step();
    res[0] = 1'b1; rr[0] = 5'd9; dd[0] = 32'h1111;
    step();
    quiet();
    sample();
    chk("r9 set wins", 32'(a_b2), 32'h1);
    chk("r9 data", 32'(a_d2), 32'h1111);
    step();

    // Sequenced clear
    for (int i = 0; i < 16; i++) wr_reg(0, i, 32'hA5A5);
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    busycnt = 0;
    for (int c = 0; c < 20; c++) begin
      wr[0] = (c == 3);
      dst[0] = 5'd3; dd[0] = 32'h7777;
      if (c == 8) begin
        sr1[0] = 5'd7;
        sr2[0] = 5'd8;
      end
      sample();
      busycnt += int'(a_busy);
      if (c == 8) begin
        chk("clear r7", 32'(a_d1), 32'h0);
        chk("clear r8", 32'(a_d2), 32'hA5A5);
      end
      step();
    end
    quiet();
    chk("clear cycles 16", 32'(busycnt), 32'd16);
    sr1[0] = 5'd3; sr2[0] = 5'd15;
    sample();
    chk("clear r3", 32'(a_d1), 32'h0);
    chk("clear r15", 32'(a_d2), 32'h0);
    step();

    // Asynchronous reset in the middle of a clear
    wr_reg(0, 2, 32'h2222);
    wr_reg(0, 12, 32'hCCCC);
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    sr1[0] = 5'd2; sr2[0] = 5'd12;
    repeat (5) step();
    #2;
    rst = 1'b1;
    #1;
    chk("rst Busy", 32'(a_busy), 32'h0);
    chk("rst r12", 32'(a_d2), 32'h0);
    step();
    rst = 1'b0;
    wr_reg(0, 4, 32'h4444);
    sr1[0] = 5'd4;
    sample();
    chk("post rst write", 32'(a_d1), 32'h4444);
    step();

    // Wide instance
    wr_reg(1, 31, 32'hDEADBEEF);
    sr1[1] = 5'd31;
    sample();
    chk("r31 wide", b_d1, 32'hDEADBEEF);
    step();
    clr[1] = 1'b1;
    step();
    clr[1] = 1'b0;
    busycnt = 0;
    for (int c = 0; c < 40; c++) begin
      sample();
      busycnt += int'(b_busy);
      step();
    end
    chk("clear cycles 32", 32'(busycnt), 32'd32);

    // Randomized traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 2; k++) begin
        dep_k  = dep(k);
        sr1[k] = 5'($urandom_range(0, dep_k - 1));
        sr2[k] = 5'($urandom_range(0, dep_k - 1));
        dst[k] = ($urandom_range(0, 3) == 0) ? sr1[k] : 5'($urandom_range(0, dep_k - 1));
        rr[k]  = 5'($urandom_range(0, dep_k - 1));
        wr[k]  = ($urandom_range(0, 1) == 1);
        res[k] = ($urandom_range(0, 9) < 4);
        clr[k] = ($urandom_range(0, 99) == 0);
        dd[k]  = $urandom & ((k == 0) ? 32'hFFFF : 32'hFFFFFFFF);
      end
      if ($urandom_range(0, 499) == 0) begin
        #2;
        rst = 1'b1;
        quiet();
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    quiet();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-ported register file for the pipelined CPU: two combinational read ports, one write port with write-through bypass.
- Generalised in WIDTH and DEPTH, with an optional hardwired zero register.
- Adds a per-register pending-write scoreboard, so decode can detect RAW hazards and stall.
- Adds a sequenced clear engine that zeroes the array one entry per cycle without asserting reset.

Parameters:
WIDTH, 16, data bits per register
DEPTH, 16, number of registers; power of two, minimum 2
AW, $clog2(DEPTH), register address width (derived; not overridden)
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes and reserves

Ports:
clk  in  1  clock, rising-edge
rst  in  1  asynchronous, active-high reset
SrcReg1  in  AW  read port 1 address
SrcReg2  in  AW  read port 2 address
SrcData1  out  WIDTH  read port 1 data (combinational)
SrcData2  out  WIDTH  read port 2 data (combinational)
Src1Busy  out  1  register at SrcReg1 has a pending write
Src2Busy  out  1  register at SrcReg2 has a pending write
DstReg  in  AW  write address
WriteReg  in  1  write enable
DstData  in  WIDTH  write data
Reserve  in  1  mark ReserveReg as pending (instruction issue)
ReserveReg  in  AW  register to reserve
ClearReq  in  1  start sequenced clear (single-cycle pulse or level)
Busy  out  1  clear sequence in progress

Behaviour:
- One clock; reset is asynchronous and active-high (clk, rst).
- Reset state:
  - All registers = 0 and all pending bits = 0.
  - FSM = IDLE, clear index = 0, Busy = 0.
  - Src*Busy = 0; SrcData* = 0.
- Reads: combinational from the array, zero latency.
  - Bypass: if WriteReg & state==IDLE & DstReg==SrcRegN & !(ZERO_REG & DstReg==0), then SrcDataN = DstData.
- Write: on rising clk, if WriteReg & state==IDLE, reg[DstReg] <= DstData.
  - With ZERO_REG=1, writes to address 0 are dropped and reads of address 0 return 0.
- Scoreboard, one pending bit per register, updated on the rising edge while IDLE:
  - WriteReg clears pend[DstReg].
  - Reserve sets pend[ReserveReg].
  - Same register hit by both in the same cycle: set wins, because the new producer supersedes the old one.
  - Reserve of register 0 is ignored when ZERO_REG=1.
- SrcNBusy = pend[SrcRegN] & !(WriteReg & state==IDLE & DstReg==SrcRegN).
  - A producer writing back this cycle does not stall its consumer; the bypass supplies the data.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when ClearReq=1. On that edge all pending bits are cleared and idx <= 0. Any WriteReg/Reserve in that cycle is discarded.
  - In CLEAR, each cycle: reg[idx] <= 0 and idx <= idx+1. When idx==DEPTH-1, go to IDLE next edge. The sequence takes exactly DEPTH cycles in CLEAR.
  - Busy = 1 while in CLEAR.
  - WriteReg, Reserve and ClearReq are ignored in CLEAR; there is no bypass and Src*Busy = 0.
  - Reads in CLEAR return current array contents: entries below idx already read 0.
  - ClearReq held high at return to IDLE restarts the sequence on the next edge.
- rst asserted mid-clear immediately forces IDLE and zeroes the array.
- All index arithmetic is modulo DEPTH. Addresses are always in range because DEPTH is a power of two.

Test Plan:
1. Reset, write 0xFFFF to r15 and 0x1234 to r1, then read SrcReg1=1, SrcReg2=15 -> SrcData1=0x1234, SrcData2=0xFFFF, both Busy=0.
2. Bypass: with r0 holding 0 and ZERO_REG=0, drive WriteReg=1, DstReg=5, DstData=0x8765, SrcReg1=5 in the same cycle -> SrcData1=0x8765 before the edge. Repeat on r0 with ZERO_REG=1 -> SrcData1=0 and r0 stays 0 after the edge.
3. Scoreboard:
   - Reserve r9, then SrcReg2=9 -> Src2Busy=1 on following cycles.
   - Write r9=0xABCD -> Src2Busy=0 in the write cycle, data 0xABCD.
   - Reserve and write r9 in the same cycle -> Src2Busy=1 afterwards.
4. Clear: fill r0..r15 with 0xA5A5, pulse ClearReq -> Busy=1 for exactly 16 cycles.
   - After 8 cycles: r7 reads 0, r8 reads 0xA5A5.
   - A WriteReg to r3 during clear is ignored.
   - End state: all reads 0 and Busy=0.
5. Reset mid-clear: assert rst asynchronously at cycle 5 of clear -> Busy=0 immediately and all registers 0. A write after rst deasserts behaves normally.
6. Parameter sweep WIDTH=32, DEPTH=32: write 0xDEADBEEF to r31, read r31 -> 0xDEADBEEF; clear -> Busy high for 32 cycles.
